// File: rtl/noc_flit_rx_endpoint_pkg.sv
// Shared types and helpers for the NoC flit receive endpoint.
// Optional packet checker in the top is enabled by NOC_RX_PKT_CHECK_EN.
package noc_flit_rx_endpoint_pkg;

    // Default link geometry; the top exposes these as overridable parameters.
    localparam int FLIT_WIDTH_DEF  = 128;
    localparam int TID_WIDTH_DEF   = 2;
    localparam int TDEST_WIDTH_DEF = 2;
    localparam int DEST_WIDTH_DEF  = TID_WIDTH_DEF + TDEST_WIDTH_DEF;

    // One flit as carried on the router link at default geometry.
    typedef struct packed {
        logic [FLIT_WIDTH_DEF-1:0] data;
        logic [DEST_WIDTH_DEF-1:0] dest;
        logic                      is_tail;
    } flit_t;

    // The dest field is packed {tid, tdest}; these split it back apart.
    function automatic logic [TID_WIDTH_DEF-1:0] dest_tid(input logic [DEST_WIDTH_DEF-1:0] dest);
        return dest[DEST_WIDTH_DEF-1:TDEST_WIDTH_DEF];
    endfunction

    function automatic logic [TDEST_WIDTH_DEF-1:0] dest_tdest(input logic [DEST_WIDTH_DEF-1:0] dest);
        return dest[TDEST_WIDTH_DEF-1:0];
    endfunction

    // Width of the lane counter; at least one bit so SF=1 stays legal.
    function automatic int cnt_width(input int sf);
        return (sf > 1) ? $clog2(sf) : 1;
    endfunction

endpackage

// File: rtl/noc_flit_rx_endpoint_fifo.sv
// Show-ahead flit FIFO: head entry is visible on rd_data whenever not empty.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module noc_flit_rx_endpoint_fifo
    import noc_flit_rx_endpoint_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push/pop pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_flit_rx_endpoint.sv
// Receive end of a credit-based router link, presented as an AXI-Stream master.
// Flits are buffered, regrouped SERIALIZATION_FACTOR per beat, and each popped
// flit returns one credit upstream. Define NOC_RX_PKT_CHECK_EN to build the
// packet integrity checker driving pkt_err; otherwise pkt_err is tied low.
//
// Handshake: a beat transfers on an edge where axis_out_tvalid and
// axis_out_tready are both high; tvalid never depends combinationally on
// tready, and tdata/tlast/tid/tdest hold steady while tvalid waits.
module noc_flit_rx_endpoint
    import noc_flit_rx_endpoint_pkg::*;
#(
    parameter int FLIT_WIDTH           = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int BUFFER_DEPTH         = 4,
    localparam int TDATA_WIDTH         = FLIT_WIDTH * SERIALIZATION_FACTOR
)(
    input  logic                   clk_noc,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err,
    output logic                   pkt_err
);

    localparam int FIFO_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int CNT_WIDTH  = cnt_width(SERIALIZATION_FACTOR);
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(SERIALIZATION_FACTOR - 1);

    logic [FIFO_WIDTH-1:0]  fifo_wr_data;
    logic [FIFO_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    logic [FLIT_WIDTH-1:0]  head_data;
    logic [DEST_WIDTH-1:0]  head_dest;
    logic                   head_tail;

    logic [CNT_WIDTH-1:0]   lane_cnt;
    logic [TDATA_WIDTH-1:0] gather_data;
    logic [TDATA_WIDTH-1:0] beat_data;
    logic                   beat_done;
    logic                   out_free;
    logic                   out_valid;

    assign fifo_wr_data = {data_in, dest_in, is_tail_in};
    assign {head_data, head_dest, head_tail} = fifo_rd_data;

    noc_flit_rx_endpoint_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clk_noc),
        .rst_n   (rst_n),
        .push    (send_in),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Lanes already gathered plus the FIFO head dropped into the current lane.
    always_comb begin
        beat_data = gather_data;
        for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
            if (CNT_WIDTH'(k) == lane_cnt) begin
                beat_data[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
            end
        end
    end

    // A beat closes on the last lane or early on a tail. A closing flit stays
    // in the FIFO until the output register can take the beat, so an idle
    // sink costs no credits beyond the one beat held in the register.
    assign beat_done = head_tail || (lane_cnt == LAST_LANE);
    assign out_free  = !out_valid || axis_out_tready;
    assign fifo_pop  = !fifo_empty && (!beat_done || out_free);

    // Gather lanes: accumulate non-closing flits, clear after a beat closes.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt    <= '0;
            gather_data <= '0;
        end else if (fifo_pop) begin
            if (beat_done) begin
                lane_cnt    <= '0;
                gather_data <= '0;
            end else begin
                lane_cnt    <= lane_cnt + 1'b1;
                gather_data <= beat_data;
            end
        end
    end

    // Output register: load a closed beat, release it once the sink takes it.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            axis_out_tdata <= '0;
            axis_out_tlast <= 1'b0;
            axis_out_tid   <= '0;
            axis_out_tdest <= '0;
        end else if (fifo_pop && beat_done) begin
            out_valid      <= 1'b1;
            axis_out_tdata <= beat_data;
            axis_out_tlast <= head_tail;
            axis_out_tid   <= head_dest[DEST_WIDTH-1:TDEST_WIDTH];
            axis_out_tdest <= head_dest[TDEST_WIDTH-1:0];
        end else if (axis_out_tready) begin
            out_valid      <= 1'b0;
        end
    end

    assign axis_out_tvalid = out_valid;

    // One credit pulse per popped flit; sticky flag for a drop on a full FIFO.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= fifo_pop;
            if (send_in && fifo_full && !fifo_pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef NOC_RX_PKT_CHECK_EN
    logic                  in_pkt;
    logic [DEST_WIDTH-1:0] pkt_dest;
    logic                  pop_in_pkt;
    logic                  pkt_err_q;
    logic                  push_ok;

    assign push_ok = send_in && (!fifo_full || fifo_pop);

    // Packet checker: body flits must match the head's dest, and for SF>1 a
    // tail of a multi-flit packet must not open a fresh beat in lane 0.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt     <= 1'b0;
            pkt_dest   <= '0;
            pop_in_pkt <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                if (in_pkt) begin
                    if (dest_in != pkt_dest) begin
                        pkt_err_q <= 1'b1;
                    end
                    if (is_tail_in) begin
                        in_pkt <= 1'b0;
                    end
                end else if (!is_tail_in) begin
                    in_pkt   <= 1'b1;
                    pkt_dest <= dest_in;
                end
            end
            if (fifo_pop) begin
                pop_in_pkt <= !head_tail;
                if ((SERIALIZATION_FACTOR > 1) && head_tail && (lane_cnt == '0) && pop_in_pkt) begin
                    pkt_err_q <= 1'b1;
                end
            end
        end
    end

    assign pkt_err = pkt_err_q;
`else
    assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_rx_endpoint.sv
// Directed bench for noc_flit_rx_endpoint: one SF=1 instance (128-bit flits)
// and one SF=4 instance (8-bit flits), both with 4-entry buffers.
module tb_noc_flit_rx_endpoint;

`ifdef NOC_RX_PKT_CHECK_EN
    localparam logic PKT_EXP = 1'b1;
`else
    localparam logic PKT_EXP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: SF=1
    logic [127:0] a_data;
    logic [3:0]   a_dest;
    logic         a_tail, a_send, a_credit, a_tvalid, a_tready, a_tlast;
    logic [127:0] a_tdata;
    logic [1:0]   a_tid, a_tdest;
    logic         a_ovf, a_pkt_err;

    // instance B: SF=4
    logic [7:0]   b_data;
    logic [3:0]   b_dest;
    logic         b_tail, b_send, b_credit, b_tvalid, b_tready, b_tlast;
    logic [31:0]  b_tdata;
    logic [1:0]   b_tid, b_tdest;
    logic         b_ovf, b_pkt_err;

    noc_flit_rx_endpoint #(
        .FLIT_WIDTH(128), .SERIALIZATION_FACTOR(1), .BUFFER_DEPTH(4)
    ) u_a (
        .clk_noc(clk), .rst_n(rst_n), .data_in(a_data), .dest_in(a_dest),
        .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_credit),
        .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready),
        .axis_out_tdata(a_tdata), .axis_out_tlast(a_tlast),
        .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
        .overflow_err(a_ovf), .pkt_err(a_pkt_err)
    );

    noc_flit_rx_endpoint #(
        .FLIT_WIDTH(8), .SERIALIZATION_FACTOR(4), .BUFFER_DEPTH(4)
    ) u_b (
        .clk_noc(clk), .rst_n(rst_n), .data_in(b_data), .dest_in(b_dest),
        .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_credit),
        .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready),
        .axis_out_tdata(b_tdata), .axis_out_tlast(b_tlast),
        .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
        .overflow_err(b_ovf), .pkt_err(b_pkt_err)
    );

    // beat capture and credit counting
    logic [127:0] a_got_d[$];
    logic [4:0]   a_got_m[$];
    logic [31:0]  b_got_d[$];
    logic [4:0]   b_got_m[$];
    int a_cred = 0;
    int b_cred = 0;

    always @(posedge clk) begin
        if (a_tvalid && a_tready) begin
            a_got_d.push_back(a_tdata);
            a_got_m.push_back({a_tlast, a_tid, a_tdest});
        end
        if (b_tvalid && b_tready) begin
            b_got_d.push_back(b_tdata);
            b_got_m.push_back({b_tlast, b_tid, b_tdest});
        end
        if (a_credit) a_cred = a_cred + 1;
        if (b_credit) b_cred = b_cred + 1;
    end

    // scoreboard counters and checks
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_beat(input string tag, input logic [127:0] exp_d, input logic [4:0] exp_m);
        if (a_got_d.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no beat expected=%0h", tag, exp_d);
        end else begin
            check({tag, "_data"}, a_got_d.pop_front(), exp_d);
            check({tag, "_meta"}, 128'(a_got_m.pop_front()), 128'(exp_m));
        end
    endtask

    task automatic check_b_beat(input string tag, input logic [31:0] exp_d, input logic [4:0] exp_m);
        if (b_got_d.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no beat expected=%0h", tag, exp_d);
        end else begin
            check({tag, "_data"}, 128'(b_got_d.pop_front()), 128'(exp_d));
            check({tag, "_meta"}, 128'(b_got_m.pop_front()), 128'(exp_m));
        end
    endtask

    // driver tasks: drive one flit at a falling edge
    task automatic send_a(input logic [127:0] d, input logic [3:0] dst, input logic t);
        @(negedge clk);
        a_send = 1'b1; a_data = d; a_dest = dst; a_tail = t;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [3:0] dst, input logic t);
        @(negedge clk);
        b_send = 1'b1; b_data = d; b_dest = dst; b_tail = t;
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_send = 1'b0;
    endtask

    task automatic idle_b();
        @(negedge clk);
        b_send = 1'b0;
    endtask

    int c0;

    initial begin
        a_data = '0; a_dest = '0; a_tail = 1'b0; a_send = 1'b0; a_tready = 1'b1;
        b_data = '0; b_dest = '0; b_tail = 1'b0; b_send = 1'b0; b_tready = 1'b1;
        rst_n = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_tvalid", a_tvalid, 1'b0);
        check("rst_a_credit", a_credit, 1'b0);
        check("rst_a_ovf", a_ovf, 1'b0);
        check("rst_b_tvalid", b_tvalid, 1'b0);
        check("rst_b_pkt_err", b_pkt_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // SF=1 single flit: latency, one credit pulse, tid/tdest split
        c0 = a_cred;
        send_a({16{8'hA5}}, 4'b1001, 1'b1);
        @(posedge clk);
        idle_a();
        @(posedge clk);
        #1;
        check("lat_tvalid", a_tvalid, 1'b1);
        check("lat_credit", a_credit, 1'b1);
        check("lat_tdata", a_tdata, {16{8'hA5}});
        @(posedge clk);
        #1;
        check("lat_credit_one_cycle", a_credit, 1'b0);
        check("lat_tvalid_drained", a_tvalid, 1'b0);
        repeat (2) @(posedge clk);
        check("single_beats", a_got_d.size(), 1);
        check_a_beat("single", {16{8'hA5}}, {1'b1, 2'b10, 2'b01});
        check("single_credits", a_cred - c0, 1);

        // SF=4: 8 back-to-back flits, tail on the last
        c0 = b_cred;
        for (int i = 0; i < 8; i++) send_b(8'(i), 4'b0110, i == 7);
        idle_b();
        repeat (8) @(posedge clk);
        #1;
        check("sf4_beats", b_got_d.size(), 2);
        check_b_beat("sf4_beat1", 32'h03020100, {1'b0, 2'b01, 2'b10});
        check_b_beat("sf4_beat2", 32'h07060504, {1'b1, 2'b01, 2'b10});
        check("sf4_credits", b_cred - c0, 8);

        // SF=4 early tail: upper lanes zero
        send_b(8'h11, 4'b0011, 1'b0);
        send_b(8'h22, 4'b0011, 1'b1);
        idle_b();
        repeat (5) @(posedge clk);
        #1;
        check_b_beat("early_tail", 32'h00002211, {1'b1, 2'b00, 2'b11});

        // SF=1 backpressure: register + 4 FIFO entries fill, 6th flit dropped
        @(negedge clk);
        a_tready = 1'b0;
        c0 = a_cred;
        for (int i = 0; i < 5; i++) send_a(128'(i + 16), 4'b0000, 1'b1);
        idle_a();
        repeat (3) @(posedge clk);
        #1;
        check("bp_credits_stalled", a_cred - c0, 1);
        check("bp_tvalid_held", a_tvalid, 1'b1);
        check("bp_tdata_held", a_tdata, 128'd16);
        check("bp_no_ovf_yet", a_ovf, 1'b0);
        send_a(128'hEE, 4'b0000, 1'b1);
        idle_a();
        check("bp_ovf", a_ovf, 1'b1);
        check("bp_credits_after_drop", a_cred - c0, 1);
        @(negedge clk);
        a_tready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_beats", a_got_d.size(), 5);
        for (int i = 0; i < 5; i++) check_a_beat($sformatf("bp_beat%0d", i), 128'(i + 16), {1'b1, 2'b00, 2'b00});
        check("bp_credits_total", a_cred - c0, 5);
        check("bp_ovf_sticky", a_ovf, 1'b1);

        // packet dest mismatch: head dest 3, body dest 5
        send_b(8'h31, 4'd3, 1'b0);
        send_b(8'h32, 4'd5, 1'b1);
        idle_b();
        repeat (6) @(posedge clk);
        #1;
        check("pkt_err_set", b_pkt_err, PKT_EXP);
        check_b_beat("pkt_beat", 32'h00003231, {1'b1, 2'b01, 2'b01});
        repeat (3) @(posedge clk);
        #1;
        check("pkt_err_sticky", b_pkt_err, PKT_EXP);
        check("pkt_b_no_ovf", b_ovf, 1'b0);

        // reset mid-packet: 2 of 4 flits in, then async reset
        send_b(8'h41, 4'b1110, 1'b0);
        send_b(8'h42, 4'b1110, 1'b0);
        @(posedge clk);
        idle_b();
        @(posedge clk);
        #1;
        check("mid_credit_before_rst", b_credit, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_credit", b_credit, 1'b0);
        check("mid_rst_tvalid", b_tvalid, 1'b0);
        check("mid_rst_a_ovf", a_ovf, 1'b0);
        check("mid_rst_pkt_err", b_pkt_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_b(8'(8'h51 + i), 4'b1110, i == 3);
        idle_b();
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_beats", b_got_d.size(), 1);
        check_b_beat("post_rst", 32'h54535251, {1'b1, 2'b11, 2'b10});
        check("post_rst_pkt_err", b_pkt_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
